// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store initiator: request handshake -> timed memory access -> extended response.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: in-range misaligned half/word run as byte sequences.
module lsu_mem_ctrl #(
  parameter int MEM_WAIT   = 0,
  parameter int ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_oob,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  SigSize,
  output logic [31:0] ADD,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  state_t r_state, w_state_next;

  logic        r_we, r_unsigned, r_split, r_oob, r_misalign;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wait_cnt;
  logic [1:0]  r_byte_idx;

  logic        w_handshake, w_oob, w_misalign, w_split;
  logic [1:0]  w_size;
  logic [2:0]  w_nbytes;
  logic [32:0] w_end;
  logic        w_wait_done, w_access_done;
  logic [1:0]  w_last_idx;
  logic [7:0]  w_wbyte;
  logic [31:0] w_wmasked, w_ext;

  assign req_ready   = (r_state == S_IDLE) & ~rst;
  assign w_handshake = req_valid & req_ready;

  // Size 11 behaves exactly like a word everywhere, so normalise it once here.
  assign w_size = req_size[1] ? 2'b10 : req_size;

  always_comb begin
    case (w_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // 33-bit end address so accesses near 2^32 cannot wrap back into range.
  assign w_end      = {1'b0, req_addr} + {30'd0, w_nbytes};
  assign w_oob      = w_end > 33'(ADDR_LIMIT);
  assign w_misalign = ((w_size == 2'b01) & req_addr[0]) |
                      ((w_size == 2'b10) & (req_addr[1:0] != 2'b00));
  assign w_split    = SPLIT_EN & w_misalign & ~w_oob;

  assign w_last_idx    = (r_size == 2'b01) ? 2'd1 : 2'd3;
  assign w_wait_done   = (r_wait_cnt == WAIT_LAST);
  assign w_access_done = w_wait_done & (~r_split | (r_byte_idx == w_last_idx));

  assign w_wbyte = r_wdata[{r_byte_idx, 3'b000} +: 8];

  always_comb begin
    case (r_size)
      2'b00:   w_wmasked = {24'd0, r_wdata[7:0]};
      2'b01:   w_wmasked = {16'd0, r_wdata[15:0]};
      default: w_wmasked = r_wdata;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{~r_unsigned & r_rdata[7]}},  r_rdata[7:0]};
      2'b01:   w_ext = {{16{~r_unsigned & r_rdata[15]}}, r_rdata[15:0]};
      default: w_ext = r_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    SigSize      = 2'b00;
    ADD          = 32'd0;
    WriteData    = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_handshake)
          w_state_next = (w_oob | (w_misalign & ~w_split)) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        MemRead  = ~r_we;
        MemWrite = r_we;
        if (r_split) begin
          ADD       = r_addr + {30'd0, r_byte_idx};
          WriteData = r_we ? {24'd0, w_wbyte} : 32'd0;
        end else begin
          SigSize   = r_size;
          ADD       = r_addr;
          WriteData = r_we ? w_wmasked : 32'd0;
        end
        if (w_access_done)
          w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_split    <= 1'b0;
      r_oob      <= 1'b0;
      r_misalign <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_wait_cnt <= 4'd0;
      r_byte_idx <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_handshake) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_size     <= w_size;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_oob      <= w_oob;
        r_misalign <= w_misalign & ~w_split & ~w_oob;
        r_split    <= w_split;
        r_rdata    <= 32'd0;
        r_wait_cnt <= 4'd0;
        r_byte_idx <= 2'd0;
      end else if (r_state == S_ACCESS) begin
        if (w_wait_done) begin
          r_wait_cnt <= 4'd0;
          // Split loads gather one byte per sub-access, little-endian.
          if (r_split) begin
            r_rdata[{r_byte_idx, 3'b000} +: 8] <= ReadData[7:0];
            r_byte_idx <= r_byte_idx + 2'd1;
          end else begin
            r_rdata <= ReadData;
          end
        end else begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end
    end
  end

  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_rdata    = (rsp_valid & ~r_we & ~r_oob & ~r_misalign) ? w_ext : 32'd0;
  assign rsp_oob      = rsp_valid & r_oob;
  assign rsp_misalign = rsp_valid & r_misalign;

endmodule
